mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and constants for the memory-port arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_DEFAULT = 8'd255;
    localparam logic [3:0] SEL_WORD        = 4'b1111;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter, data side has priority over instruction fetch
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ce_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] i_data_o,
    output logic        i_ready_o,
    input  logic        d_ce_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_data_i,
    output logic [31:0] d_data_o,
    output logic        d_ready_o,
    input  logic        flush_i,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_data_o,
    input  logic [31:0] m_data_i,
    input  logic        m_ack_i,
    output logic        stallreq_o,
    output logic        bus_err_o
);

    state_t     state;
    logic [7:0] tmo_cnt;
    logic       timed_out;

    assign timed_out  = (tmo_cnt == TIMEOUT - 8'd1);
    assign stallreq_o = (d_ce_i & ~d_ready_o) | (i_ce_i & ~i_ready_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            m_req_o   <= 1'b0;
            m_we_o    <= 1'b0;
            m_addr_o  <= 32'h0;
            m_sel_o   <= 4'h0;
            m_data_o  <= 32'h0;
            i_data_o  <= 32'h0;
            d_data_o  <= 32'h0;
            i_ready_o <= 1'b0;
            d_ready_o <= 1'b0;
            bus_err_o <= 1'b0;
            tmo_cnt   <= 8'h0;
        end else begin
            i_ready_o <= 1'b0;
            d_ready_o <= 1'b0;
            bus_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A requester whose ready is pulsing this cycle is not re-granted.
                    if (d_ce_i == CHIP_ENABLE && !d_ready_o) begin
                        m_req_o  <= 1'b1;
                        m_we_o   <= d_we_i;
                        m_addr_o <= d_addr_i;
                        m_sel_o  <= d_sel_i;
                        m_data_o <= d_data_i;
                        tmo_cnt  <= 8'h0;
                        state    <= ST_DATA;
                    end else if (i_ce_i == CHIP_ENABLE && !i_ready_o) begin
                        m_req_o  <= 1'b1;
                        m_we_o   <= WRITE_DISABLE;
                        m_addr_o <= i_addr_i;
                        m_sel_o  <= SEL_WORD;
                        tmo_cnt  <= 8'h0;
                        state    <= ST_FETCH;
                    end
                end
                ST_DATA: begin
                    if (m_ack_i) begin
                        m_req_o   <= 1'b0;
                        d_ready_o <= 1'b1;
                        if (m_we_o != WRITE_ENABLE) begin
                            d_data_o <= m_data_i;
                        end
                        state <= ST_IDLE;
                    end else if (timed_out) begin
                        m_req_o   <= 1'b0;
                        bus_err_o <= 1'b1;
                        d_ready_o <= 1'b1;
                        d_data_o  <= 32'h0;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_FETCH: begin
                    if (m_ack_i) begin
                        m_req_o <= 1'b0;
                        if (!flush_i) begin
                            i_data_o  <= m_data_i;
                            i_ready_o <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (timed_out) begin
                        m_req_o   <= 1'b0;
                        bus_err_o <= 1'b1;
                        if (!flush_i) begin
                            i_ready_o <= 1'b1;
                            i_data_o  <= 32'h0;
                        end
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (flush_i) begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    // The bus cycle must still finish; its result is simply thrown away.
                    if (m_ack_i) begin
                        m_req_o <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (timed_out) begin
                        m_req_o   <= 1'b0;
                        bus_err_o <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
